// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 definitions: prefix/response bytes, decoder FSM states and
// 9-bit {extended, scan code} key codes used by ps2_key_mapper.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   // Pause make is E1 14 77 E1 F0 14 F0 77: the bytes after the first E1.
   localparam int PAUSE_SKIP_BYTES = 7;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      SKIP
   } ps2_state_t;

   localparam logic [8:0] KEY_LEFT  = 9'h16B;
   localparam logic [8:0] KEY_RIGHT = 9'h174;
   localparam logic [8:0] KEY_UP    = 9'h175;
   localparam logic [8:0] KEY_DOWN  = 9'h172;
   localparam logic [8:0] KEY_SPACE = 9'h029;
   localparam logic [8:0] KEY_ESC   = 9'h076;

   function automatic logic is_ctrl_response(input logic [7:0] b);
      return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) || (b == PS2_RESEND);
   endfunction

endpackage

// File: rtl/ps2_repeat_timer.sv
// Per-key software auto-repeat timer: first pulse REPEAT_DELAY cycles after a
// press, then every REPEAT_PERIOD cycles while the key stays held.
module ps2_repeat_timer #(
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic hold,
   output logic repeat_pulse
);

   localparam int SPAN  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CNT_W = $clog2(SPAN + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] age_next;
   logic             periodic;
   logic             fire;

   always_comb begin
      age_next = (cnt == CNT_W'(SPAN)) ? cnt : cnt + 1'b1;
      fire     = periodic ? (age_next == CNT_W'(REPEAT_PERIOD))
                          : (age_next == CNT_W'(REPEAT_DELAY));
   end

   // start and hold are the next-cycle press/held values, so a press that
   // coincides with an expiry restarts the count without a repeat pulse.
   always_ff @(posedge clk) begin
      if (reset || start || !hold) begin
         cnt          <= '0;
         periodic     <= 1'b0;
         repeat_pulse <= 1'b0;
      end else if (fire) begin
         cnt          <= '0;
         periodic     <= 1'b1;
         repeat_pulse <= 1'b1;
      end else begin
         cnt          <= age_next;
         repeat_pulse <= 1'b0;
      end
   end

endmodule

// File: rtl/ps2_key_mapper.sv
// PS/2 set-2 make/break decoder for NUM_KEYS configurable keys with typematic
// suppression and prefix timeout. Optional auto-repeat: define PS2_KEY_REPEAT_EN.
module ps2_key_mapper
   import ps2_pkg::*;
#(
   parameter int                    NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {KEY_DOWN, KEY_UP, KEY_RIGHT, KEY_LEFT},
   parameter int                    TIMEOUT_CYCLES = 2_500_000,
   parameter int                    REPEAT_DELAY   = 25_000_000,
   parameter int                    REPEAT_PERIOD  = 5_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          ps2_data,
   input  logic                ps2_valid,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                any_held,
   output logic                seq_error
);

   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SKIP_W = $clog2(PAUSE_SKIP_BYTES + 1);

   ps2_state_t          state, state_next;
   logic [TO_W-1:0]     to_cnt, to_cnt_next;
   logic [SKIP_W-1:0]   skip_cnt, skip_cnt_next;
   logic                timeout_hit;
   logic                do_make;
   logic                do_break;
   logic                code_ext;
   logic [NUM_KEYS-1:0] match;
   logic [NUM_KEYS-1:0] held_next;
   logic [NUM_KEYS-1:0] press_next;
   logic [NUM_KEYS-1:0] release_next;

   always_comb begin
      state_next    = state;
      skip_cnt_next = skip_cnt;
      do_make       = 1'b0;
      do_break      = 1'b0;
      code_ext      = 1'b0;
      timeout_hit   = 1'b0;
      if (ps2_valid) begin
         case (state)
            IDLE: begin
               if (ps2_data == PS2_EXT) begin
                  state_next = EXT;
               end else if (ps2_data == PS2_BRK) begin
                  state_next = BRK;
               end else if (ps2_data == PS2_PAUSE) begin
                  state_next    = SKIP;
                  skip_cnt_next = SKIP_W'(PAUSE_SKIP_BYTES);
               end else if (!is_ctrl_response(ps2_data)) begin
                  do_make = 1'b1;
               end
            end
            EXT: begin
               if (ps2_data == PS2_BRK) begin
                  state_next = EXT_BRK;
               end else if (ps2_data != PS2_EXT) begin
                  do_make    = 1'b1;
                  code_ext   = 1'b1;
                  state_next = IDLE;
               end
            end
            BRK: begin
               if (ps2_data != PS2_BRK) begin
                  do_break   = 1'b1;
                  state_next = IDLE;
               end
            end
            EXT_BRK: begin
               if (ps2_data != PS2_BRK) begin
                  do_break   = 1'b1;
                  code_ext   = 1'b1;
                  state_next = IDLE;
               end
            end
            SKIP: begin
               if (skip_cnt <= SKIP_W'(1)) begin
                  skip_cnt_next = '0;
                  state_next    = IDLE;
               end else begin
                  skip_cnt_next = skip_cnt - 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end else if ((state != IDLE) && (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1))) begin
         // A stalled prefix is abandoned; held keys keep their state.
         timeout_hit   = 1'b1;
         state_next    = IDLE;
         skip_cnt_next = '0;
      end
   end

   always_comb begin
      if (ps2_valid || (state_next == IDLE)) begin
         to_cnt_next = '0;
      end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
         to_cnt_next = to_cnt + 1'b1;
      end else begin
         to_cnt_next = to_cnt;
      end
   end

   // Every channel carrying the decoded {ext, code} follows the event.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         match[i] = (KEY_CODES[9*i +: 9] == {code_ext, ps2_data});
      end
   end

   always_comb begin
      held_next = key_held;
      if (do_make) begin
         held_next = key_held | match;
      end else if (do_break) begin
         held_next = key_held & ~match;
      end
      press_next   = held_next & ~key_held;
      release_next = key_held & ~held_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         to_cnt      <= '0;
         skip_cnt    <= '0;
         key_held    <= '0;
         key_press   <= '0;
         key_release <= '0;
         any_held    <= 1'b0;
         seq_error   <= 1'b0;
      end else begin
         state       <= state_next;
         to_cnt      <= to_cnt_next;
         skip_cnt    <= skip_cnt_next;
         key_held    <= held_next;
         key_press   <= press_next;
         key_release <= release_next;
         any_held    <= |held_next;
         seq_error   <= timeout_hit;
      end
   end

`ifdef PS2_KEY_REPEAT_EN
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_repeat
      ps2_repeat_timer #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_repeat_timer (
         .clk         (clk),
         .reset       (reset),
         .start       (press_next[i]),
         .hold        (held_next[i]),
         .repeat_pulse(key_repeat[i])
      );
   end
`else
   // No timers; the repeat parameters only fold into this constant tie-off.
   assign key_repeat = {NUM_KEYS{(REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0)}};
`endif

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper with a byte-level behavioural model and
// per-cycle output comparison; repeat checks apply when PS2_KEY_REPEAT_EN is set.
module tb_ps2_key_mapper;

   localparam int             NK    = 4;
   localparam logic [NK*9-1:0] CODES = {9'h172, 9'h175, 9'h174, 9'h16B};
   localparam int             TO    = 40;
   localparam int             RD    = 30;
   localparam int             RP    = 10;
`ifdef PS2_KEY_REPEAT_EN
   localparam bit             REP_ON = 1'b1;
`else
   localparam bit             REP_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    ps2_data;
   logic          ps2_valid;
   logic [NK-1:0] key_held, key_press, key_release, key_repeat;
   logic          any_held, seq_error;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int press1_cnt = 0;
   int seq_cnt = 0;
   int rep3_cnt = 0;

   logic [NK-1:0] m_held = '0, m_press = '0, m_rel = '0, m_rep = '0;
   logic          m_seq = 1'b0;

   ps2_key_mapper #(
      .NUM_KEYS      (NK),
      .KEY_CODES     (CODES),
      .TIMEOUT_CYCLES(TO),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_data   (ps2_data),
      .ps2_valid  (ps2_valid),
      .key_held   (key_held),
      .key_press  (key_press),
      .key_release(key_release),
      .key_repeat (key_repeat),
      .any_held   (any_held),
      .seq_error  (seq_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge so calls chain back-to-back.
   task automatic send(input logic [7:0] b);
      ps2_data  = b;
      ps2_valid = 1'b1;
      @(negedge clk);
      ps2_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: collect prefix bytes in a queue and resolve the key event from them.
   initial begin
      logic [7:0] pre[$];
      logic [7:0] b;
      logic [NK-1:0] old;
      int  skip_left = 0;
      int  idle_ct = 0;
      int  age[NK];
      bit  ext, brk;
      for (int i = 0; i < NK; i++) age[i] = 0;
      forever begin
         @(posedge clk);
         old   = m_held;
         m_seq = 1'b0;
         if (reset) begin
            pre.delete();
            skip_left = 0;
            idle_ct   = 0;
            m_held = '0; m_press = '0; m_rel = '0; m_rep = '0;
            for (int i = 0; i < NK; i++) age[i] = 0;
         end else begin
            if (ps2_valid) begin
               idle_ct = 0;
               b = ps2_data;
               ext = 1'b0;
               brk = 1'b0;
               foreach (pre[k]) begin
                  if (pre[k] == 8'hE0) ext = 1'b1;
                  if (pre[k] == 8'hF0) brk = 1'b1;
               end
               if (skip_left > 0) skip_left--;
               else if (pre.size() == 0 && b == 8'hE1) skip_left = 7;
               else if (b == 8'hE0 && !brk) pre.push_back(b);
               else if (b == 8'hF0) pre.push_back(b);
               else if (pre.size() == 0 && (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE)) begin
               end else begin
                  for (int i = 0; i < NK; i++)
                     if (CODES[9*i +: 9] == {ext, b}) m_held[i] = !brk;
                  pre.delete();
               end
            end else if (pre.size() > 0 || skip_left > 0) begin
               idle_ct++;
               if (idle_ct == TO) begin
                  pre.delete();
                  skip_left = 0;
                  idle_ct   = 0;
                  m_seq     = 1'b1;
               end
            end
            m_press = m_held & ~old;
            m_rel   = old & ~m_held;
            for (int i = 0; i < NK; i++) begin
               if (!REP_ON || !m_held[i] || m_press[i]) begin
                  age[i]   = 0;
                  m_rep[i] = 1'b0;
               end else begin
                  age[i]++;
                  m_rep[i] = (age[i] >= RD) && (((age[i] - RD) % RP) == 0);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (key_press[1] === 1'b1) press1_cnt++;
         if (seq_error === 1'b1) seq_cnt++;
         if (key_repeat[3] === 1'b1) rep3_cnt++;
         if (chk_en) begin
            check("cyc_held",    key_held,    m_held);
            check("cyc_press",   key_press,   m_press);
            check("cyc_release", key_release, m_rel);
            check("cyc_repeat",  key_repeat,  m_rep);
            check("cyc_any",     any_held,    |m_held);
            check("cyc_seqerr",  seq_error,   m_seq);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      reset     = 1'b1;
      ps2_valid = 1'b0;
      ps2_data  = 8'h00;
      idle(3);
      chk_en = 1'b1;
      check("rst_held", key_held, 0);
      check("rst_any", any_held, 0);
      check("rst_seqerr", seq_error, 0);
      reset = 1'b0;
      idle(2);

      // Extended make/break of left arrow on channel 0.
      send(8'hE0); send(8'h6B);
      check("ext_make_held", key_held, 4'b0001);
      check("ext_make_press", key_press, 4'b0001);
      idle(10);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("ext_break_held", key_held, 4'b0000);
      check("ext_break_release", key_release, 4'b0001);
      idle(3);

      // Typematic repeats of right arrow give one press.
      snap = press1_cnt;
      for (int r = 0; r < 5; r++) begin
         send(8'hE0); send(8'h74); idle(3);
      end
      check("typematic_held", key_held, 4'b0010);
      check("typematic_presses", press1_cnt - snap, 1);
      send(8'hE0); send(8'hF0); send(8'h74);
      send(8'hE0); send(8'hF0); send(8'h74);
      idle(3);
      check("typematic_release", key_held, 4'b0000);

      // Plain 6B is keypad 4, not left arrow.
      send(8'h6B);
      idle(2);
      check("plain_6b_held", key_held, 4'b0000);

      // Pause sequence and ACK are discarded; decoder is back in IDLE after.
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      idle(2);
      send(8'hFA);
      idle(2);
      check("pause_held", key_held, 4'b0000);
      send(8'hE0); send(8'h75);
      check("pause_then_up", key_held, 4'b0100);
      idle(3);

      // Prefix timeout, then a plain 74 must not hit the extended channel.
      snap = seq_cnt;
      send(8'hE0);
      idle(TO + 5);
      check("timeout_pulses", seq_cnt - snap, 1);
      send(8'h74);
      idle(2);
      check("timeout_held", key_held, 4'b0100);
      send(8'hF0); send(8'hF0); send(8'h75);
      idle(2);
      check("plain_break_ignored", key_held, 4'b0100);

      // Reset between E0 and F0.
      send(8'hE0); send(8'h72);
      check("down_held", key_held, 4'b1100);
      send(8'hE0);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      check("reset_held", key_held, 4'b0000);
      check("reset_any", any_held, 0);
      send(8'h72);
      idle(2);
      check("reset_fsm_idle", key_held, 4'b0000);

      // Hold down arrow: repeats at RD then every RP.
      snap = rep3_cnt;
      send(8'hE0); send(8'h72);
      idle(55);
      check("repeat_count", rep3_cnt - snap, REP_ON ? 3 : 0);
      send(8'hE0); send(8'hF0); send(8'h72);
      idle(20);
      check("repeat_stops", key_repeat, 4'b0000);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_mapper.md
# ps2_key_mapper

Parametrised PS/2 set-2 scan-code decoder that tracks make/break state for `NUM_KEYS` configurable keys and reports held levels, press pulses and release pulses. It handles the extended (`E0`), break (`F0`) and Pause (`E1`) prefixes, suppresses keyboard typematic repeats and recovers from truncated prefix sequences. It sits between the PS/2 controller's received-byte strobe and game control logic (lane moves, pause, restart), and replaces the fixed two-arrow decoder.

## Interface
- `NUM_KEYS`, 4: number of decoded key channels (1..16).
- `KEY_CODES`, `{9'h172,9'h175,9'h174,9'h16B}`: packed `NUM_KEYS*9` bits. Channel i is `[9i+8:9i]`. Bit 8 is the extended flag; bits 7:0 are the scan code. The default is down, up, right, left.
- `TIMEOUT_CYCLES`, 2_500_000: maximum idle cycles allowed inside a prefix state (50 ms at 50 MHz).
- `REPEAT_DELAY`, 25_000_000: cycles a key is held before the first software repeat (only with the macro).
- `REPEAT_PERIOD`, 5_000_000: cycles between later repeats (only with the macro).
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `ps2_data` input 8: received byte. Valid only while `ps2_valid` is high.
- `ps2_valid` input 1: single-cycle strobe, one per byte.
- `key_held` output NUM_KEYS: level. Bit i is 1 between the make and break of key i.
- `key_press` output NUM_KEYS: 1-cycle pulse on the 0→1 transition of `key_held[i]`.
- `key_release` output NUM_KEYS: 1-cycle pulse on the 1→0 transition of `key_held[i]`.
- `key_repeat` output NUM_KEYS: 1-cycle software auto-repeat pulses.
- `any_held` output 1: OR of `key_held`.
- `seq_error` output 1: 1-cycle pulse when a prefix timeout forces the FSM back to IDLE.

## Operation
- **FSM states:** IDLE, EXT, BRK, EXT_BRK, SKIP.
- **IDLE transitions:**
  - `E0` → EXT.
  - `F0` → BRK.
  - `E1` → SKIP, with the skip counter loaded to 7.
  - Any other byte is a non-extended make → IDLE.
- **EXT transitions:**
  - `F0` → EXT_BRK.
  - `E0` → stay in EXT.
  - Any other byte is an extended make → IDLE.
- **BRK transitions:**
  - `F0` → stay in BRK.
  - Any other byte is a non-extended break → IDLE.
- **EXT_BRK transitions:** `F0` → stay in EXT_BRK. Any other byte is an extended break → IDLE.
- **SKIP:** decrement on each strobe and go to IDLE when the counter reaches 0. The Pause sequence is discarded.
- **Make:** sets `key_held[i]` for every channel whose 9-bit code equals `{ext, byte}`. Duplicate table entries all update.
- **Break:** clears the matching channels.
- **Ignored bytes:** unmatched codes, and controller responses `FA`, `AA`, `EE`, `FE` seen in IDLE, are ignored with no state change.
- **Typematic suppression:** a repeated make for a key already held leaves `key_held` at 1 and generates no `key_press`. The same holds for a break of a key already released and `key_release`.
- **Timeout:** a cycle counter clears on every strobe and counts while the FSM is in EXT, BRK, EXT_BRK or SKIP. On reaching `TIMEOUT_CYCLES`, the FSM goes to IDLE and `seq_error` pulses. `key_held` is unchanged.
- **Reset mid-sequence:** FSM returns to IDLE, counters clear, all outputs go to 0, and no pulses are generated.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE.
- **Latency:** `key_held`, `key_press` and `key_release` update on the clock edge that samples the final byte's `ps2_valid`, so they are visible 1 cycle after the strobe. `key_press` and `key_held` rise in the same cycle.
- **Pulse width:** pulses are exactly 1 cycle. Back-to-back strobes on consecutive cycles must be accepted.
- **Outputs:** `any_held` is registered together with `key_held`.
- **Counter widths:** sized with `$clog2(param+1)`. Counters saturate and never wrap.

## Configuration
- **`PS2_KEY_REPEAT_EN` defined:** each channel owns a repeat timer.
  - The timer clears on `key_press`.
  - `key_repeat[i]` first pulses when `REPEAT_DELAY` cycles have elapsed after `key_press`.
  - It then pulses every `REPEAT_PERIOD` cycles while held.
  - The timer stops on release.
  - If a press and a timer expiry coincide, the press wins: the timer restarts and no repeat pulse is generated.
- **`PS2_KEY_REPEAT_EN` not defined:** `key_repeat` is tied to 0 and no timers are synthesised. All other behaviour is identical.

## Structure
- **Shared package `ps2_pkg`:**
  - Constants `PS2_EXT=8'hE0`, `PS2_BRK=8'hF0`, `PS2_PAUSE=8'hE1`, `PS2_ACK=8'hFA`, `PS2_BAT=8'hAA`, `PS2_ECHO=8'hEE`, `PS2_RESEND=8'hFE`.
  - The FSM state typedef.
  - 9-bit key codes `KEY_LEFT`, `KEY_RIGHT`, `KEY_UP`, `KEY_DOWN`, `KEY_SPACE`, `KEY_ESC`.
- **Sub-module `ps2_repeat_timer`:** one instance per channel via generate, built only when the macro is defined.

## Test plan
- **Extended make/break:** strobe `E0 6B`, then after 10 cycles `E0 F0 6B`. Required response: `key_held[0]=1` with a `key_press[0]` pulse 1 cycle after the `6B` strobe, then `key_held[0]=0` with one `key_release[0]` pulse. Other channels stay 0.
- **Typematic:** strobe `E0 74` five times. Required response: `key_held[1]=1` and exactly one `key_press[1]` pulse.
- **Extended vs. plain code:** strobe a plain `6B`, which is keypad 4 and not extended. Required response: no change on channel 0.
- **Pause and ignored bytes:** strobe `E1 14 77 E1 F0 14 F0 77`, then `FA`. Required response: no outputs change and the FSM ends in IDLE. A following `E0 75` sets `key_held[2]`.
- **Timeout:** strobe `E0` and then wait `TIMEOUT_CYCLES`. Required response: a `seq_error` pulse, and a following `74` does not set channel 1.
- **Reset and repeat:** assert `reset` between `E0` and `F0`. Required response: all outputs 0 and the FSM in IDLE. With `PS2_KEY_REPEAT_EN` defined, holding `E0 72` gives `key_repeat[3]` at `REPEAT_DELAY` and then every `REPEAT_PERIOD`.
